snd_write_fifo: RTL
===================

Name: snd_write_fifo

Overview:
- Sits between memory_interface and sn76489. It replaces the hard-wired 8'h00 sound bus and the raw BWE/address-decode chip enable.
- Watches decoded host memory cycles in the clk domain and captures every host byte write to the sound port (>84xx).
- Queues captured bytes in a small FIFO and replays each one to sn76489 with its own chip-enable/write-enable pulse, long enough for the slow sound core to sample.
- Decouples the host write timing from the sound core's write timing.

Parameters:
- DEPTH, 4, FIFO entries. Must be a power of two, 2..16.
- ADDR_HI, 8'h84, value matched against address bus [15:8].
- WE_CYCLES, 32, clk cycles that o_snd_we is held low per replayed byte. Range 1..255.

Ports:
- clk  input  1  100 MHz system clock
- reset  input  1  asynchronous, active-low reset
- i_memen  input  1  host MEMEN, active low, asynchronous to clk
- i_we  input  1  host WE, active low, asynchronous to clk
- i_address_bus  input  16  decoded address from memory_interface, stable in clk domain during the cycle
- i_data_bus  input  8  data byte from memory_interface, stable while i_we is low
- o_snd_data  output  8  byte presented to sn76489 i_data_bus
- o_snd_cs  output  1  sound chip select, active low
- o_snd_we  output  1  sound write enable, active low
- o_fifo_count  output  5  number of entries queued, 0..DEPTH
- o_overflow  output  1  sticky; a write was dropped
- i_clear_overflow  input  1  synchronous clear of o_overflow

Behaviour:
- Reset (reset=0) values: o_snd_data=8'h00, o_snd_cs=1, o_snd_we=1, o_fifo_count=0, o_overflow=0, FSM=IDLE, read/write pointers=0.
- Synchronisers: i_we and i_memen each pass through a 2-flop synchroniser; the second stage is called we_s / memen_s. Both synchroniser stages reset to 1.
- Qualification: while we_s=0, set pending=1 if memen_s=0 and i_address_bus[15:8]==ADDR_HI, and latch i_data_bus into cap_data on every such cycle. The last value sampled before deassertion wins.
- Push: on the we_s 0->1 edge with pending=1, push cap_data, then clear pending. If we_s returns high and the cycle did not qualify, clear pending and push nothing.
- Push latency: exactly 1 clk after the we_s rising edge is detected, o_fifo_count increments. This holds unless a pop happens in the same cycle; then the count is unchanged.
- Full: a push when count==DEPTH and no pop in the same cycle is dropped. It sets o_overflow=1, and the FIFO contents are unchanged.
- Simultaneous push and pop when full: the push is accepted.
- Overflow clear: i_clear_overflow=1 clears o_overflow on the next clk. If an overflow event occurs in the same cycle, set takes priority.
- Replay FSM:
  - IDLE: if count>0, pop the head into o_snd_data and go to SETUP. Otherwise o_snd_cs=1 and o_snd_we=1.
  - SETUP (1 clk): o_snd_cs=0, o_snd_we=1.
  - STROBE (WE_CYCLES clk): o_snd_cs=0, o_snd_we=0. An 8-bit down-counter is loaded with WE_CYCLES-1 on entry.
  - HOLD (1 clk): o_snd_cs=0, o_snd_we=1, o_snd_data still stable.
  - After HOLD, return to IDLE. o_snd_cs is 1 in the IDLE cycle, so there is a minimum 1-clk gap between bytes.
- Total bus occupancy per byte: WE_CYCLES+2 clk with cs low. Back-to-back replay period is WE_CYCLES+3.
- o_snd_data holds the last popped byte in IDLE. It never changes while o_snd_cs=0.
- Pointers wrap modulo DEPTH. o_fifo_count is an explicit counter, not derived from pointer difference.
- Bytes are replayed in strict push order. There is no bit reordering; host bus bit order is handled upstream.
- Reset asserted mid-replay: the FSM returns to IDLE immediately, the FIFO empties, and cs/we deassert asynchronously. No partial strobe is resumed after reset.

Test Plan:
- Single write: one host write of 8'h9F to >8400 (MEMEN=0, WE low 300 ns) -> count goes 0->1->0; one cs-low window of 34 clk with we low for 32 clk; o_snd_data=8'h9F throughout.
- Non-matching address: write of 8'h55 to >8800, plus a read cycle at >8400 (WE high) -> count stays 0; cs and we stay 1.
- Burst: 4 back-to-back writes 8'h80, 8'h05, 8'h92, 8'h9F faster than replay -> count peaks at 3 or 4; four strobes in order 80, 05, 92, 9F; each strobe is separated by at least 1 clk with cs=1.
- Overflow: 6 writes within one replay period with DEPTH=4 -> exactly 4 + (pops during the burst) bytes replayed; o_overflow=1 and stays set until i_clear_overflow pulses; then reads 0.
- Full plus simultaneous pop: count==4 and the FSM pops in the same clk as a push -> push accepted, count stays 4, no overflow.
- Reset mid-STROBE: assert reset 10 clk into STROBE with 2 entries queued -> o_snd_we and o_snd_cs go to 1 immediately; count=0 after release; no further strobes.

Source files
------------

// File: rtl/snd_write_fifo.sv
// Captures host byte writes to the sound port and replays each byte to the
// sn76489 with a slow chip-select/write-enable strobe, decoupled by a small FIFO.
module snd_write_fifo #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [7:0]  ADDR_HI   = 8'h84,
    parameter int unsigned WE_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_memen,
    input  logic        i_we,
    input  logic [15:0] i_address_bus,
    input  logic [7:0]  i_data_bus,
    output logic [7:0]  o_snd_data,
    output logic        o_snd_cs,
    output logic        o_snd_we,
    output logic [4:0]  o_fifo_count,
    output logic        o_overflow,
    input  logic        i_clear_overflow
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  FULL_C = 5'(DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t             state;
    logic               we_m, we_s, we_d;
    logic               memen_m, memen_s;
    logic               pending;
    logic [7:0]         cap_data;
    logic [7:0]         mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [7:0]         strobe_cnt;
    logic               push, pop, accept, drop;
    logic               unused_addr_lo;

    assign unused_addr_lo = ^i_address_bus[7:0];

    // A push is qualified on the synchronised WE rising edge only if some
    // low cycle of that host write hit the sound port.
    assign push   = we_s & ~we_d & pending;
    assign pop    = (state == IDLE) && (o_fifo_count != '0);
    assign accept = push && ((o_fifo_count != FULL_C) || pop);
    assign drop   = push && !accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_m     <= 1'b1;
            we_s     <= 1'b1;
            we_d     <= 1'b1;
            memen_m  <= 1'b1;
            memen_s  <= 1'b1;
            pending  <= 1'b0;
            cap_data <= '0;
        end else begin
            we_m    <= i_we;
            we_s    <= we_m;
            we_d    <= we_s;
            memen_m <= i_memen;
            memen_s <= memen_m;
            if (!we_s) begin
                if (!memen_s && (i_address_bus[15:8] == ADDR_HI)) begin
                    pending  <= 1'b1;
                    cap_data <= i_data_bus;
                end
            end else begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= cap_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_fifo_count <= '0;
            o_overflow   <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   o_fifo_count <= o_fifo_count + 1'b1;
                2'b01:   o_fifo_count <= o_fifo_count - 1'b1;
                default: o_fifo_count <= o_fifo_count;
            endcase
            if (drop)
                o_overflow <= 1'b1;
            else if (i_clear_overflow)
                o_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            o_snd_data <= '0;
            o_snd_cs   <= 1'b1;
            o_snd_we   <= 1'b1;
            strobe_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        o_snd_data <= mem[rd_ptr];
                        o_snd_cs   <= 1'b0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    o_snd_we   <= 1'b0;
                    strobe_cnt <= 8'(WE_CYCLES - 1);
                    state      <= STROBE;
                end
                STROBE: begin
                    if (strobe_cnt == '0) begin
                        o_snd_we <= 1'b1;
                        state    <= HOLD;
                    end else begin
                        strobe_cnt <= strobe_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    o_snd_cs <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
